// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: opcodes, instruction field layout,
// sequencer states and small decode helpers.
package alu_issue_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int IDX_W  = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_ROT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int F_OP_HI    = 31;
  localparam int F_OP_LO    = 29;
  localparam int F_DST_HI   = 28;
  localparam int F_DST_LO   = 26;
  localparam int F_SRC1_HI  = 25;
  localparam int F_SRC1_LO  = 23;
  localparam int F_SRC2_HI  = 22;
  localparam int F_SRC2_LO  = 20;
  localparam int F_USE_IMM  = 19;
  localparam int F_SHAMT_HI = 18;
  localparam int F_SHAMT_LO = 13;
  localparam int F_IMM_HI   = 12;
  localparam int F_IMM_LO   = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        use_imm;
    logic [5:0]  shamt;
    logic [12:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  function automatic instr_t decode(input logic [DATA_W-1:0] word);
    instr_t f;
    f.op      = word[F_OP_HI:F_OP_LO];
    f.dst     = word[F_DST_HI:F_DST_LO];
    f.src1    = word[F_SRC1_HI:F_SRC1_LO];
    f.src2    = word[F_SRC2_HI:F_SRC2_LO];
    f.use_imm = word[F_USE_IMM];
    f.shamt   = word[F_SHAMT_HI:F_SHAMT_LO];
    f.imm     = word[F_IMM_HI:F_IMM_LO];
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] imm_zext(input logic [12:0] imm);
    return {19'b0, imm};
  endfunction

  function automatic logic op_writes_back(input logic [2:0] op);
    case (op)
      OP_ADD, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SHL, OP_ROT: return 1'b1;
      OP_ILL:  return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x32 register file: one synchronous write port, two operand reads and one debug read, all combinational.
// Latency: reads 0 cycles, write visible the cycle after we; no backpressure.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr1,
  input  logic [IDX_W-1:0]  raddr2,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_idx];

endmodule

// File: rtl/alu_issue.sv
// Issue sequencer for the combinational ALU: accept, hold ALU ports ALU_LAT cycles, write back.
// Latency: accept edge to done = ALU_LAT+1 cycles; in_ready low through EXEC and WB (one op per ALU_LAT+2).
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_sr1,
  output logic [31:0] alu_sr2,
  output logic [2:0]  alu_os,
  output logic [5:0]  alu_shift,
  input  logic [31:0] alu_rd,
  output logic        done,
  output logic [31:0] result,
  output logic        z_flag,
  output logic        err,
  input  logic [2:0]  dbg_idx,
  output logic [31:0] dbg_data
);

  localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        dst_q, dst_d;
  logic [31:0]       sr1_q, sr1_d;
  logic [31:0]       sr2_q, sr2_d;
  logic [5:0]        shift_q, shift_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              z_q, z_d;

  instr_t            dec;
  logic [31:0]       rd1, rd2;
  logic              wb_we;

  assign dec = decode(in_instr);

  alu_issue_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_we),
    .waddr    (dst_q),
    .wdata    (cap_q),
    .raddr1   (dec.src1),
    .raddr2   (dec.src2),
    .dbg_idx  (dbg_idx),
    .rdata1   (rd1),
    .rdata2   (rd2),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dst_d    = dst_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    shift_d  = shift_q;
    cap_d    = cap_q;
    result_d = result_q;
    z_d      = z_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wb_we    = 1'b0;
    in_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = dec.op;
          dst_d   = dec.dst;
          sr1_d   = rd1;
          sr2_d   = dec.use_imm ? imm_zext(dec.imm) : rd2;
          shift_d = dec.shamt;
          cnt_d   = 3'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU ports are the latched operand flops, so they stay put for the whole window.
        if (cnt_q == CNT_LAST) begin
          cap_d   = alu_rd;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (op_writes_back(op_q)) begin
          wb_we    = 1'b1;
          result_d = cap_q;
          z_d      = (cap_q == 32'd0);
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      shift_q  <= '0;
      cap_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      z_q      <= z_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign alu_sr1   = sr1_q;
  assign alu_sr2   = sr2_q;
  assign alu_os    = op_q;
  assign alu_shift = shift_q;
  assign result    = result_q;
  assign done      = done_q;
  assign err       = err_q;
  assign z_flag    = z_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (ALU_LAT=1 and ALU_LAT=3) each driving a behavioural ALU,
// a schedule-level model checked every cycle, and directed vectors with hand-computed results.
module tb_alu_issue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  dbg_idx;
  logic        in_valid [2];
  logic [31:0] in_instr [2];
  logic        in_ready [2];
  logic        done     [2];
  logic        err      [2];
  logic        z_flag   [2];
  logic [31:0] alu_sr1  [2];
  logic [31:0] alu_sr2  [2];
  logic [31:0] alu_rd   [2];
  logic [31:0] result   [2];
  logic [31:0] dbg_data [2];
  logic [2:0]  alu_os   [2];
  logic [5:0]  alu_shift[2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] sh);
    logic [63:0] dbl;
    dbl = {a, a} << sh[4:0];
    case (op)
      3'b000:  return a + b;
      3'b001:  return a | b;
      3'b010:  return a & b;
      3'b011:  return a ^ b;
      3'b100:  return ~(a | b);
      3'b101:  return (sh >= 6'd32) ? 32'd0 : (a << sh);
      3'b110:  return dbl[63:32];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] dst,
                                     input logic [2:0] s1, input logic [2:0] s2, input logic ui,
                                     input logic [5:0] sh, input logic [12:0] imm);
    return {op, dst, s1, s2, ui, sh, imm};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  assign alu_rd[0] = alu_ref(alu_os[0], alu_sr1[0], alu_sr2[0], alu_shift[0]);
  assign alu_rd[1] = alu_ref(alu_os[1], alu_sr1[1], alu_sr2[1], alu_shift[1]);

  alu_issue #(.ALU_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_instr(in_instr[0]), .alu_sr1(alu_sr1[0]), .alu_sr2(alu_sr2[0]), .alu_os(alu_os[0]),
    .alu_shift(alu_shift[0]), .alu_rd(alu_rd[0]), .done(done[0]), .result(result[0]),
    .z_flag(z_flag[0]), .err(err[0]), .dbg_idx(dbg_idx), .dbg_data(dbg_data[0])
  );

  alu_issue #(.ALU_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_instr(in_instr[1]), .alu_sr1(alu_sr1[1]), .alu_sr2(alu_sr2[1]), .alu_os(alu_os[1]),
    .alu_shift(alu_shift[1]), .alu_rd(alu_rd[1]), .done(done[1]), .result(result[1]),
    .z_flag(z_flag[1]), .err(err[1]), .dbg_idx(dbg_idx), .dbg_data(dbg_data[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- schedule-level model, one per instance ----------------
  int          busy     [2];
  logic [31:0] m_regs   [2][8];
  logic [31:0] m_res    [2];
  logic [31:0] m_sr1    [2];
  logic [31:0] m_sr2    [2];
  logic [31:0] pend_val [2];
  logic [2:0]  m_os     [2];
  logic [2:0]  pend_dst [2];
  logic [5:0]  m_sh     [2];
  logic        m_z      [2];
  logic        m_done   [2];
  logic        m_err    [2];
  bit          mdl_on = 1'b0;

  always @(negedge clk) begin
    logic [31:0] ins, a, b;
    for (int d = 0; d < 2; d++) begin
      if (mdl_on) begin
        chk1($sformatf("in_ready[%0d]", d), in_ready[d], busy[d] == 0);
        chk1($sformatf("done[%0d]", d), done[d], m_done[d]);
        chk1($sformatf("err[%0d]", d), err[d], m_err[d]);
        chk1($sformatf("z_flag[%0d]", d), z_flag[d], m_z[d]);
        chk($sformatf("result[%0d]", d), result[d], m_res[d]);
        chk($sformatf("alu_sr1[%0d]", d), alu_sr1[d], m_sr1[d]);
        chk($sformatf("alu_sr2[%0d]", d), alu_sr2[d], m_sr2[d]);
        chk($sformatf("alu_os[%0d]", d), 32'(alu_os[d]), 32'(m_os[d]));
        chk($sformatf("alu_shift[%0d]", d), 32'(alu_shift[d]), 32'(m_sh[d]));
        chk($sformatf("dbg_data[%0d]", d), dbg_data[d], m_regs[d][dbg_idx]);
      end
      m_done[d] = 1'b0;
      m_err[d]  = 1'b0;
      if (reset) begin
        busy[d] = 0;
        for (int r = 0; r < 8; r++) m_regs[d][r] = 32'd0;
        m_res[d] = 32'd0; m_sr1[d] = 32'd0; m_sr2[d] = 32'd0;
        m_os[d] = 3'd0; m_sh[d] = 6'd0; m_z[d] = 1'b0;
        pend_val[d] = 32'd0; pend_dst[d] = 3'd0;
      end else if (busy[d] == 0) begin
        if (in_valid[d]) begin
          ins = in_instr[d];
          a = m_regs[d][ins[25:23]];
          b = ins[19] ? {19'd0, ins[12:0]} : m_regs[d][ins[22:20]];
          m_sr1[d] = a;
          m_sr2[d] = b;
          m_os[d]  = ins[31:29];
          m_sh[d]  = ins[18:13];
          pend_val[d] = alu_ref(ins[31:29], a, b, ins[18:13]);
          pend_dst[d] = ins[28:26];
          busy[d] = lat_of(d) + 1;
        end
      end else begin
        busy[d]--;
        if (busy[d] == 0) begin
          if (m_os[d] != 3'b111) begin
            m_regs[d][pend_dst[d]] = pend_val[d];
            m_res[d]  = pend_val[d];
            m_z[d]    = (pend_val[d] == 32'd0);
            m_done[d] = 1'b1;
          end else begin
            m_err[d] = 1'b1;
          end
        end
      end
    end
    if (reset) mdl_on = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] exp;
    bit          ill;
    bit          expz;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] t3   [4];
  logic [31:0] exp0 [8];
  logic [31:0] exp1 [8];
  int          acc  [4];

  task automatic run_vec(input int idx, input vec_t v);
    int  k;
    bit  got;
    in_instr[0] = v.ins;
    in_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (in_ready[0]) got = 1'b1;
    end
    if (!got) begin
      chk1($sformatf("accept_timeout v%0d", idx), 1'b0, 1'b1);
      in_valid[0] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk($sformatf("exec_os v%0d", idx), 32'(alu_os[0]), 32'(v.ins[31:29]));
    chk($sformatf("exec_shift v%0d", idx), 32'(alu_shift[0]), 32'(v.ins[18:13]));
    k = 0;
    got = 1'b0;
    while (!got && k < 10) begin
      @(posedge clk); #1;
      k++;
      if (done[0] || err[0]) got = 1'b1;
    end
    chk($sformatf("latency v%0d", idx), 32'(k), 32'd2);
    if (v.ill) begin
      chk1($sformatf("err v%0d", idx), err[0], 1'b1);
      chk1($sformatf("no_done v%0d", idx), done[0], 1'b0);
    end else begin
      chk1($sformatf("done v%0d", idx), done[0], 1'b1);
      chk($sformatf("result v%0d", idx), result[0], v.exp);
    end
    chk1($sformatf("z v%0d", idx), z_flag[0], v.expz);
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    dbg_idx = 3'd0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_instr[d] = 32'd0;
    end

    vecs[0]  = '{mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 6'd0, 13'd5),       32'd5,          1'b0, 1'b0};
    vecs[1]  = '{mk(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 6'd0, 13'd0),       32'd10,         1'b0, 1'b0};
    vecs[2]  = '{mk(3'd3, 3'd3, 3'd2, 3'd2, 1'b0, 6'd0, 13'd0),       32'd0,          1'b0, 1'b1};
    vecs[3]  = '{mk(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 6'd0, 13'd1),       32'd1,          1'b0, 1'b0};
    vecs[4]  = '{mk(3'd5, 3'd7, 3'd6, 3'd0, 1'b1, 6'd31, 13'd0),      32'h8000_0000,  1'b0, 1'b0};
    vecs[5]  = '{mk(3'd1, 3'd1, 3'd7, 3'd0, 1'b1, 6'd0, 13'd1),       32'h8000_0001,  1'b0, 1'b0};
    vecs[6]  = '{mk(3'd6, 3'd4, 3'd1, 3'd0, 1'b1, 6'd1, 13'd0),       32'h0000_0003,  1'b0, 1'b0};
    vecs[7]  = '{mk(3'd0, 3'd2, 3'd7, 3'd7, 1'b0, 6'd0, 13'd0),       32'd0,          1'b0, 1'b1};
    vecs[8]  = '{mk(3'd7, 3'd5, 3'd1, 3'd0, 1'b1, 6'd0, 13'h1F),      32'd0,          1'b1, 1'b1};
    vecs[9]  = '{mk(3'd2, 3'd6, 3'd1, 3'd0, 1'b1, 6'd0, 13'h1FFF),    32'd1,          1'b0, 1'b0};
    vecs[10] = '{mk(3'd4, 3'd5, 3'd3, 3'd0, 1'b1, 6'd0, 13'h1000),    32'hFFFF_EFFF,  1'b0, 1'b0};

    exp0 = '{32'd0, 32'h8000_0001, 32'd0, 32'd0, 32'd3, 32'hFFFF_EFFF, 32'd1, 32'h8000_0000};

    t3[0] = mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 6'd0, 13'd7);
    t3[1] = mk(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 6'd0, 13'd3);
    t3[2] = mk(3'd3, 3'd3, 3'd1, 3'd2, 1'b0, 6'd0, 13'd0);
    t3[3] = mk(3'd5, 3'd4, 3'd3, 3'd0, 1'b1, 6'd4, 13'd0);
    exp1 = '{32'd0, 32'd7, 32'd10, 32'd13, 32'hD0, 32'd0, 32'd0, 32'd0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk1("rst in_ready", in_ready[0], 1'b1);
    chk1("rst done", done[0], 1'b0);
    chk1("rst err", err[0], 1'b0);
    chk1("rst z_flag", z_flag[0], 1'b0);
    chk("rst result", result[0], 32'd0);
    chk("rst alu_sr1", alu_sr1[0], 32'd0);
    chk("rst alu_sr2", alu_sr2[0], 32'd0);
    chk("rst alu_os", 32'(alu_os[0]), 32'd0);
    chk("rst alu_shift", 32'(alu_shift[0]), 32'd0);
    chk1("rst in_ready lat3", in_ready[1], 1'b1);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    repeat (2) @(posedge clk);
    for (int r = 0; r < 8; r++) begin
      dbg_idx = 3'(r);
      #1;
      chk($sformatf("final lat1 reg%0d", r), dbg_data[0], exp0[r]);
    end

    // Continuous in_valid on the ALU_LAT=3 instance: accepts must land 5 cycles apart.
    @(posedge clk); #1;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr[1] = t3[i];
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        @(negedge clk);
        if (in_ready[1]) got = 1'b1;
      end
      if (!got) chk1($sformatf("bp accept_timeout %0d", i), 1'b0, 1'b1);
      acc[i] = cyc;
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0;
    for (int i = 1; i < 4; i++) chk($sformatf("bp spacing %0d", i), 32'(acc[i] - acc[i-1]), 32'd5);
    repeat (8) @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) begin
      dbg_idx = 3'(r);
      #1;
      chk($sformatf("final lat3 reg%0d", r), dbg_data[1], exp1[r]);
    end

    // Reset landing in the EXEC cycle of the ALU_LAT=1 instance.
    @(posedge clk); #1;
    in_instr[0] = mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 6'd0, 13'd9);
    in_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (in_ready[0]) got = 1'b1;
    end
    chk1("midexec accepted", got, 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk1("midexec busy", in_ready[0], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk1("midexec ready after reset", in_ready[0], 1'b1);
    chk1("midexec no done", done[0], 1'b0);
    chk("midexec result", result[0], 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk1($sformatf("midexec no done +%0d", t + 1), done[0], 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      dbg_idx = 3'(r);
      #1;
      chk($sformatf("midexec lat1 reg%0d", r), dbg_data[0], 32'd0);
      chk($sformatf("midexec lat3 reg%0d", r), dbg_data[1], 32'd0);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by t=%0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
